// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one mux-plus-register stage between 2^switch_bits
// requesters; the captured word is presented downstream on a valid/ready handshake.
module mux_arbiter #(
    parameter int switch_bits = 2,
    parameter int data_width  = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [(1<<switch_bits)-1:0]              req_IN,
    input  logic [(1<<switch_bits)*data_width-1:0]   data_IN,
    input  logic                                     ready_IN,
    output logic [(1<<switch_bits)-1:0]              grant_OUT,
    output logic [switch_bits-1:0]                   sel_OUT,
    output logic                                     valid_OUT,
    output logic [data_width-1:0]                    data_OUT
);

    localparam int N = 1 << switch_bits;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [switch_bits-1:0] ptr_q, ptr_d;
    logic [switch_bits-1:0] sel_q, sel_d;
    logic [N-1:0]           grant_q, grant_d;
    logic [data_width-1:0]  data_q, data_d;

    logic [data_width-1:0]  words [N];
    logic [N-1:0]           mreq;
    logic [switch_bits-1:0] win;
    logic [switch_bits-1:0] idx;
    logic                   found;
    logic                   capture;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            words[i] = data_IN[i*data_width +: data_width];
        end
    end

    // A requester granted last cycle sits out one arbitration so a stale word is never re-captured.
    always_comb begin
        mreq  = req_IN & ~grant_q;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr_q + switch_bits'(k);
            if (!found && mreq[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        capture = found && ((state_q == IDLE) || ready_IN);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        grant_d = '0;
        if (capture) begin
            state_d      = BUSY;
            ptr_d        = win + switch_bits'(1);
            sel_d        = win;
            data_d       = words[win];
            grant_d[win] = 1'b1;
        end else if (state_q == BUSY && ready_IN) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            data_q  <= data_d;
        end
    end

    assign valid_OUT = (state_q == BUSY);
    assign grant_OUT = grant_q;
    assign sel_OUT   = sel_q;
    assign data_OUT  = data_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: a vector table applied one edge per entry,
// preceded by hand-written reset and asynchronous-reset sequences.
module tb_mux_arbiter;

    localparam int SB = 2;
    localparam int W  = 8;
    localparam int N  = 1 << SB;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_IN;
    logic [N*W-1:0]   data_IN;
    logic             ready_IN;
    logic [N-1:0]     grant_OUT;
    logic [SB-1:0]    sel_OUT;
    logic             valid_OUT;
    logic [W-1:0]     data_OUT;

    int errors = 0;
    int checks = 0;

    mux_arbiter #(.switch_bits(SB), .data_width(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_IN    (req_IN),
        .data_IN   (data_IN),
        .ready_IN  (ready_IN),
        .grant_OUT (grant_OUT),
        .sel_OUT   (sel_OUT),
        .valid_OUT (valid_OUT),
        .data_OUT  (data_OUT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] data;
        logic           ready;
        logic           exp_valid;
        logic [N-1:0]   exp_grant;
        logic [SB-1:0]  exp_sel;
        logic [W-1:0]   exp_data;
    } vec_t;

    vec_t vecs[$];

    localparam logic [N*W-1:0] D0 = 32'h1312_1110;
    localparam logic [N*W-1:0] DA = 32'h13A5_1110;

    task automatic add(input logic [N-1:0] req, input logic [N*W-1:0] data, input logic ready,
                       input logic ev, input logic [N-1:0] eg, input logic [SB-1:0] es,
                       input logic [W-1:0] ed);
        vec_t v;
        v.req = req; v.data = data; v.ready = ready;
        v.exp_valid = ev; v.exp_grant = eg; v.exp_sel = es; v.exp_data = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [N-1:0] eg,
                             input logic [SB-1:0] es, input logic [W-1:0] ed);
        check({tag, ".valid"}, 32'(valid_OUT), 32'(ev));
        check({tag, ".grant"}, 32'(grant_OUT), 32'(eg));
        check({tag, ".sel"},   32'(sel_OUT),   32'(es));
        check({tag, ".data"},  32'(data_OUT),  32'(ed));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // single requester 2, then drop -> IDLE
        add(4'b0100, DA, 1'b1, 1'b1, 4'b0100, 2'd2, 8'hA5);
        add(4'b0000, DA, 1'b1, 1'b0, 4'b0000, 2'd2, 8'hA5);
        add(4'b0000, DA, 1'b1, 1'b0, 4'b0000, 2'd2, 8'hA5);
        // wrap-around from ptr=3 with req=0011
        add(4'b0011, D0, 1'b1, 1'b1, 4'b0001, 2'd0, 8'h10);
        add(4'b0011, D0, 1'b1, 1'b1, 4'b0010, 2'd1, 8'h11);
        add(4'b0000, D0, 1'b1, 1'b0, 4'b0000, 2'd1, 8'h11);
        // steer ptr back to 0
        add(4'b1000, D0, 1'b1, 1'b1, 4'b1000, 2'd3, 8'h13);
        add(4'b0000, D0, 1'b1, 1'b0, 4'b0000, 2'd3, 8'h13);
        // full contention, one word per cycle
        add(4'b1111, D0, 1'b1, 1'b1, 4'b0001, 2'd0, 8'h10);
        add(4'b1111, D0, 1'b1, 1'b1, 4'b0010, 2'd1, 8'h11);
        add(4'b1111, D0, 1'b1, 1'b1, 4'b0100, 2'd2, 8'h12);
        add(4'b1111, D0, 1'b1, 1'b1, 4'b1000, 2'd3, 8'h13);
        add(4'b1111, D0, 1'b1, 1'b1, 4'b0001, 2'd0, 8'h10);
        add(4'b1111, D0, 1'b1, 1'b1, 4'b0010, 2'd1, 8'h11);
        // backpressure for 5 cycles while holding 0x11
        for (int i = 0; i < 5; i++) add(4'b1111, D0, 1'b0, 1'b1, 4'b0000, 2'd1, 8'h11);
        add(4'b1111, D0, 1'b1, 1'b1, 4'b0100, 2'd2, 8'h12);
        add(4'b0000, D0, 1'b1, 1'b0, 4'b0000, 2'd2, 8'h12);
        // single continuous requester 1: valid alternates
        add(4'b0010, D0, 1'b1, 1'b1, 4'b0010, 2'd1, 8'h11);
        add(4'b0010, D0, 1'b1, 1'b0, 4'b0000, 2'd1, 8'h11);
        add(4'b0010, D0, 1'b1, 1'b1, 4'b0010, 2'd1, 8'h11);
        add(4'b0000, D0, 1'b1, 1'b0, 4'b0000, 2'd1, 8'h11);
        // ready ignored in IDLE, hold while BUSY with ready=0
        add(4'b0100, D0, 1'b0, 1'b1, 4'b0100, 2'd2, 8'h12);
        add(4'b0000, D0, 1'b0, 1'b1, 4'b0000, 2'd2, 8'h12);
        add(4'b0000, D0, 1'b1, 1'b0, 4'b0000, 2'd2, 8'h12);

        // reset held with all requests active
        rst = 1'b0; req_IN = 4'b1111; data_IN = D0; ready_IN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold", 1'b0, 4'b0000, 2'd0, 8'h00);

        // first edge after release picks requester 0
        rst = 1'b1;
        @(posedge clk); #1;
        check_all("reset_release", 1'b1, 4'b0001, 2'd0, 8'h10);

        // asynchronous reset between edges while BUSY
        #2;
        rst = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 4'b0000, 2'd0, 8'h00);
        rst = 1'b1; req_IN = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            req_IN   = vecs[i].req;
            data_IN  = vecs[i].data;
            ready_IN = vecs[i].ready;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_grant,
                      vecs[i].exp_sel, vecs[i].exp_data);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
